// File: rtl/test_neuron.sv
// Sequential 784-input neuron: one multiply-accumulate per clock, saturated signed Q8.18 result.
// Optional macro TEST_NEURON_RELU_EN clamps negative results to zero.
module test_neuron #(
  parameter int N  = 784,
  parameter int PW = 10,
  parameter int WW = 19,
  parameter int WF = 18,
  parameter int OW = 26,
  parameter int AW = 40
) (
  input  logic                clk,
  input  logic                GlobalReset,
  input  logic [N*PW-1:0]     Pixels,
  input  logic [N*WW-1:0]     Weights,
  output logic [OW-1:0]       value,
  output logic                done
);

  localparam int IW  = $clog2(N);
  localparam int PRW = PW + WW;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic signed [PRW-1:0] prod_q, prod_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic [OW-1:0]        value_q, value_d;
  logic                 done_q, done_d;

  logic [PW-1:0] pix_arr [N];
  logic [WW-1:0] wgt_arr [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_unpack
    assign pix_arr[gi] = Pixels[gi*PW +: PW];
    assign wgt_arr[gi] = Weights[gi*WW +: WW];
  end

  logic signed [PRW-1:0] pix_ext, wgt_ext;
  logic signed [AW-1:0]  acc_sum;
  logic                  pos_ovf, neg_ovf;
  logic [OW-1:0]         sat_val;

  always_comb begin
    pix_ext = {{(PRW-PW){1'b0}}, pix_arr[idx_q]};
    wgt_ext = {{(PRW-WW){wgt_arr[idx_q][WW-1]}}, wgt_arr[idx_q]};
    acc_sum = acc_q + {{(AW-PRW){prod_q[PRW-1]}}, prod_q};
    // Overflow when the bits above the output sign bit disagree with the accumulator sign.
    pos_ovf = !acc_sum[AW-1] && (|acc_sum[AW-2:OW-1]);
    neg_ovf =  acc_sum[AW-1] && !(&acc_sum[AW-2:OW-1]);
    if (pos_ovf)
      sat_val = {1'b0, {(OW-1){1'b1}}};
    else if (neg_ovf)
      sat_val = {1'b1, {(OW-1){1'b0}}};
    else
      sat_val = {acc_sum[OW-1:WF], acc_sum[WF-1:0]};
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    prod_d  = prod_q;
    acc_d   = acc_q;
    value_d = value_q;
    done_d  = done_q;
    case (state_q)
      IDLE: begin
        state_d = RUN;
        idx_d   = '0;
      end
      RUN: begin
        prod_d = pix_ext * wgt_ext;
        acc_d  = acc_sum;
        if (idx_q == IW'(N-1)) begin
          state_d = FLUSH;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      FLUSH: begin
        // Last product is folded in here and the result is registered in the same edge.
        acc_d   = acc_sum;
        prod_d  = '0;
        done_d  = 1'b1;
        state_d = DONE;
`ifdef TEST_NEURON_RELU_EN
        value_d = sat_val[OW-1] ? '0 : sat_val;
`else
        value_d = sat_val;
`endif
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      prod_q  <= '0;
      acc_q   <= '0;
      value_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      prod_q  <= prod_d;
      acc_q   <= acc_d;
      value_q <= value_d;
      done_q  <= done_d;
    end
  end

  assign value = value_q;
  assign done  = done_q;

endmodule

// File: tb/tb_test_neuron.sv
// Scoreboard bench for test_neuron: stimulus pushes expected results, a monitor checks them when done rises.
module tb_test_neuron;

  localparam int N  = 784;
  localparam int PW = 10;
  localparam int WW = 19;
  localparam int OW = 26;

  logic              clk = 1'b0;
  logic              GlobalReset = 1'b0;
  logic [N*PW-1:0]   Pixels = '0;
  logic [N*WW-1:0]   Weights = '0;
  logic [OW-1:0]     value;
  logic              done;

  int n_vec = 0;
  int n_err = 0;

  logic [OW-1:0] exp_q [$];
  string         name_q [$];

  test_neuron dut (
    .clk        (clk),
    .GlobalReset(GlobalReset),
    .Pixels     (Pixels),
    .Weights    (Weights),
    .value      (value),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end else begin
      $display("ok   %s: %h", nm, act);
    end
  endtask

  // Monitor: compare the result on every rising edge of done.
  initial begin : monitor
    logic done_prev;
    done_prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (done === 1'b1 && done_prev !== 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_done: value %h, no result expected", value);
        end else begin
          string         nm;
          logic [OW-1:0] e;
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          check(nm, value, e);
        end
      end
      done_prev = done;
    end
  end

  task automatic set_all(input logic [PW-1:0] pix, input logic [WW-1:0] w);
    for (int k = 0; k < N; k++) begin
      Pixels[k*PW +: PW]  = pix;
      Weights[k*WW +: WW] = w;
    end
  endtask

  task automatic run_vector(input string nm, input logic [OW-1:0] exp, input bit abort);
    int            cyc;
    logic          quiet;
    logic          held;
    logic [OW-1:0] v0;
    GlobalReset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check({nm, "_rst_value"}, value, '0);
    check({nm, "_rst_done"}, OW'(done), '0);
    if (abort) begin
      GlobalReset = 1'b1;
      repeat (400) @(posedge clk);
      #3;
      GlobalReset = 1'b0;
      #1;
      check({nm, "_abort_value"}, value, '0);
      check({nm, "_abort_done"}, OW'(done), '0);
      repeat (2) @(posedge clk);
      @(negedge clk);
    end
    exp_q.push_back(exp);
    name_q.push_back(nm);
    GlobalReset = 1'b1;
    cyc   = 0;
    quiet = 1'b1;
    while (cyc < 790) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done === 1'b1) break;
      if (value !== '0) quiet = 1'b0;
    end
    check({nm, "_latency"}, OW'(cyc), OW'(786));
    check({nm, "_quiet_run"}, OW'(quiet), OW'(1));
    if (done !== 1'b1) begin
      void'(exp_q.pop_back());
      void'(name_q.pop_back());
    end else begin
      v0   = value;
      held = 1'b1;
      repeat (100) begin
        @(posedge clk);
        #1;
        if (value !== v0 || done !== 1'b1) held = 1'b0;
      end
      check({nm, "_hold"}, OW'(held), OW'(1));
      #2;
      GlobalReset = 1'b0;
      #1;
      check({nm, "_async_clr_value"}, value, '0);
      check({nm, "_async_clr_done"}, OW'(done), '0);
    end
  endtask

  initial begin : stimulus
    logic [OW-1:0] exp_neg98, exp_negsat, exp_mixed;
`ifdef TEST_NEURON_RELU_EN
    exp_neg98  = 26'h0000000;
    exp_negsat = 26'h0000000;
`else
    exp_neg98  = 26'h2780000;
    exp_negsat = 26'h2000000;
`endif
    exp_mixed = 26'h05603FF;

    // 392 odd pixels of 1 times 0.125 -> 49.0
    for (int k = 0; k < N; k++) begin
      Pixels[k*PW +: PW]  = PW'(k % 2);
      Weights[k*WW +: WW] = 19'h08000;
    end
    run_vector("half_ones", 26'h0C40000, 1'b0);
    run_vector("abort_restart", 26'h0C40000, 1'b1);

    set_all(10'd0, 19'h0);
    for (int k = 0; k < N; k++) Weights[k*WW +: WW] = WW'($urandom);
    run_vector("zero_pixels", 26'h0000000, 1'b0);

    set_all(10'd1, 19'h78000);
    run_vector("neg_98", exp_neg98, 1'b0);

    set_all(10'd1023, 19'h3FFFF);
    run_vector("pos_sat", 26'h1FFFFFF, 1'b0);

    set_all(10'd1023, 19'h40000);
    run_vector("neg_sat", exp_negsat, 1'b0);

    // -5 + 1023*2^-18 + 25 + 1.5 = 21.5 plus 1023 LSBs
    set_all(10'd0, 19'h2AAAA);
    Pixels[0*PW +: PW]    = 10'd5;
    Weights[0*WW +: WW]   = 19'h40000;
    Pixels[1*PW +: PW]    = 10'd1023;
    Weights[1*WW +: WW]   = 19'h00001;
    Pixels[782*PW +: PW]  = 10'd100;
    Weights[782*WW +: WW] = 19'h10000;
    Pixels[783*PW +: PW]  = 10'd3;
    Weights[783*WW +: WW] = 19'h20000;
    run_vector("mixed_frac", exp_mixed, 1'b0);

    repeat (5) @(posedge clk);
    check("scoreboard_drained", OW'(exp_q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, %0d results outstanding", exp_q.size());
    $fatal(1, "timeout");
  end

endmodule
